// File: rtl/lnrv_ifu_itcm_ctrl.sv
// ---------------------------------------------------------------------------
// lnrv_ifu_itcm_ctrl
//
// Instruction TCM controller placed directly upstream of the IFU fetch stage.
// It terminates the fetch command/response channels and drives a single-port
// synchronous SRAM that has one cycle of read latency. When the fetch stage
// stalls, one response is parked in an internal hold register. Misaligned or
// out-of-window accesses return an error without touching the SRAM. Writes
// return an error too unless the write feature is compiled in.
//
// Optional feature macro: LNRV_ITCM_WRITE_EN
//   defined     : aligned in-window writes go to the SRAM (byte masked).
//   not defined : every write is answered with an error, sram_we tied low.
//
// Parameters
//   P_ADDR_BASE  : byte base address of the ITCM window
//   P_DEPTH_LOG2 : log2 of SRAM depth in 32-bit words
//
// Ports
//   i_clk, i_reset_n          : clock, synchronous active-low reset
//   i_cmd_vld / o_cmd_rdy     : command handshake
//   i_cmd_write               : 1 = write, 0 = read
//   i_cmd_addr                : byte address
//   i_cmd_wdata / i_cmd_wstrb : write data and byte strobes
//   o_rsp_vld / i_rsp_rdy     : response handshake
//   o_rsp_rdata / o_rsp_err   : read data (0 unless good read) and error flag
//   o_sram_*                  : SRAM chip select, write enable, word address,
//                               write data, byte write mask
//   i_sram_rdata              : SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module lnrv_ifu_itcm_ctrl #(
    parameter logic [31:0] P_ADDR_BASE  = 32'h0000_0000,
    parameter int          P_DEPTH_LOG2 = 14
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_cmd_vld,
    output logic                    o_cmd_rdy,
    input  logic                    i_cmd_write,
    input  logic [31:0]             i_cmd_addr,
    input  logic [31:0]             i_cmd_wdata,
    input  logic [3:0]              i_cmd_wstrb,
    output logic                    o_rsp_vld,
    input  logic                    i_rsp_rdy,
    output logic [31:0]             o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_sram_cs,
    output logic                    o_sram_we,
    output logic [P_DEPTH_LOG2-1:0] o_sram_addr,
    output logic [31:0]             o_sram_wdata,
    output logic [3:0]              o_sram_wem,
    input  logic [31:0]             i_sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RESP = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_read;
    logic        r_err;
    logic [31:0] r_hold_data;

    logic [31:0] w_offs;
    logic        w_in_range;
    logic        w_misalgn;
    logic        w_good;
    logic        w_cmd_rdy;
    logic        w_cmd_hsked;
    logic [31:0] w_rsp_rdata;

    // Address decode; an address below the base wraps to a huge offset and
    // therefore falls out of range on its own.
    assign w_offs     = i_cmd_addr - P_ADDR_BASE;
    assign w_in_range = (w_offs >> (P_DEPTH_LOG2 + 2)) == 32'd0;
    assign w_misalgn  = i_cmd_addr[1:0] != 2'b00;

`ifdef LNRV_ITCM_WRITE_EN
    assign w_good    = w_in_range & ~w_misalgn;
    assign o_sram_we = o_sram_cs & i_cmd_write;
`else
    assign w_good    = w_in_range & ~w_misalgn & ~i_cmd_write;
    assign o_sram_we = 1'b0;
`endif

    // A new command is taken when nothing is pending or the pending response
    // leaves this very cycle; reset_n gating keeps the channel closed in reset.
    assign w_cmd_rdy   = i_reset_n & ((r_state == ST_IDLE) | i_rsp_rdy);
    assign w_cmd_hsked = i_cmd_vld & w_cmd_rdy;
    assign o_cmd_rdy   = w_cmd_rdy;

    assign o_sram_cs    = w_cmd_hsked & w_good;
    assign o_sram_addr  = w_offs[P_DEPTH_LOG2+1:2];
    assign o_sram_wdata = i_cmd_wdata;
    assign o_sram_wem   = i_cmd_wstrb;

    // Next-state selection for the response tracker.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hsked) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP, ST_HOLD: begin
                if (!i_rsp_rdy) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_cmd_hsked) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Response data: live SRAM output right after the read, parked copy once
    // stalled, zero for writes, errors and when no response is presented.
    always_comb begin
        w_rsp_rdata = 32'd0;
        if (i_reset_n && r_is_read) begin
            case (r_state)
                ST_RESP: w_rsp_rdata = i_sram_rdata;
                ST_HOLD: w_rsp_rdata = r_hold_data;
                default: w_rsp_rdata = 32'd0;
            endcase
        end else begin
            w_rsp_rdata = 32'd0;
        end
    end

    assign o_rsp_vld   = i_reset_n & (r_state != ST_IDLE);
    assign o_rsp_err   = o_rsp_vld & r_err;
    assign o_rsp_rdata = w_rsp_rdata;

    // State register, per-response flags and stall hold register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_is_read   <= 1'b0;
            r_err       <= 1'b0;
            r_hold_data <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_hsked) begin
                r_is_read <= w_good & ~i_cmd_write;
                r_err     <= ~w_good;
            end
            // The SRAM output is only valid for one cycle, so capture it the
            // moment the first stall cycle is seen. r_err needs no copy: no
            // command can be accepted while the response is stalled.
            if ((r_state == ST_RESP) && !i_rsp_rdy) begin
                r_hold_data <= r_is_read ? i_sram_rdata : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_lnrv_ifu_itcm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lnrv_ifu_itcm_ctrl
//
// Scoreboard bench: the stimulus side computes the expected response of each
// accepted command from a word-array reference of the ITCM contents and the
// access rules (alignment, window, write enable), and queues it. A monitor
// on the falling edge pops and compares whenever a response is consumed, and
// checks latency, stall stability and reset behaviour. A behavioural SRAM
// drives 32'hDEAD_BEEF whenever it was not read on the previous edge.
// ---------------------------------------------------------------------------
module tb_lnrv_ifu_itcm_ctrl;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          DLOG2     = 14;
    localparam int          WORDS     = 1 << DLOG2;
    localparam logic [32:0] WIN_BYTES = 33'd1 << (DLOG2 + 2);
`ifdef LNRV_ITCM_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_vld;
    logic              cmd_rdy;
    logic              cmd_write;
    logic [31:0]       cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              sram_cs;
    logic              sram_we;
    logic [DLOG2-1:0]  sram_addr;
    logic [31:0]       sram_wdata;
    logic [3:0]        sram_wem;
    logic [31:0]       sram_q = 32'd0;

    lnrv_ifu_itcm_ctrl #(.P_ADDR_BASE(BASE), .P_DEPTH_LOG2(DLOG2)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_cmd_vld    (cmd_vld),
        .o_cmd_rdy    (cmd_rdy),
        .i_cmd_write  (cmd_write),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_wdata  (cmd_wdata),
        .i_cmd_wstrb  (cmd_wstrb),
        .o_rsp_vld    (rsp_vld),
        .i_rsp_rdy    (rsp_rdy),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_sram_cs    (sram_cs),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .o_sram_wem   (sram_wem),
        .i_sram_rdata (sram_q)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: one-cycle read latency, garbage when not read.
    logic [31:0] sram_mem [0:WORDS-1];
    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wem[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
        if (sram_cs && !sram_we) sram_q <= sram_mem[sram_addr];
        else                     sram_q <= 32'hDEAD_BEEF;
    end

    // Reference ITCM contents and expected-response queue.
    logic [31:0] ref_mem [0:WORDS-1];
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned cyc;
    } rsp_t;
    rsp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    function automatic bit access_ok(input logic [31:0] a, input logic w);
        logic [31:0] off;
        off = a - BASE;
        return ((a % 32'd4) == 32'd0) && ({1'b0, off} < WIN_BYTES) && (!w || WR_EN);
    endfunction

    // Present one command, wait (bounded) for acceptance, check the SRAM side
    // against the access rules and queue the expected response.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int waits);
        bit          ok;
        logic [31:0] off;
        int          idx;
        rsp_t        e;
        cmd_vld = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        waits = 0;
        @(negedge clk);
        while (!cmd_rdy && waits < 20) begin
            @(posedge clk); #1;
            rsp_rdy = 1'b1;
            waits++;
            @(negedge clk);
        end
        if (!cmd_rdy) begin
            check("cmd_accept_timeout", 32'(cmd_rdy), 32'd1);
        end else begin
            ok  = access_ok(a, w);
            off = a - BASE;
            idx = int'(off >> 2);
            check("sram_cs", 32'(sram_cs), 32'(ok));
            check("sram_we", 32'(sram_we), 32'(ok && w));
            if (ok) check("sram_addr", 32'(sram_addr), off >> 2);
            if (ok && w) begin
                check("sram_wem", 32'(sram_wem), 32'(s));
                check("sram_wdata", sram_wdata, d);
            end
            e.err   = !ok;
            e.rdata = (ok && !w) ? ref_mem[idx] : 32'd0;
            e.cyc   = cyc;
            if (ok && w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    // Monitor: compares every consumed response with the scoreboard.
    logic        mon_stall = 1'b0;
    logic [31:0] mon_data  = 32'd0;
    logic        mon_err   = 1'b0;
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
                check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
                check("rst_rsp_rdata", rsp_rdata, 32'd0);
                check("rst_rsp_err", 32'(rsp_err), 32'd0);
                check("rst_sram_cs", 32'(sram_cs), 32'd0);
                check("rst_sram_we", 32'(sram_we), 32'd0);
                mon_stall = 1'b0;
            end else if (!rsp_vld) begin
                check("idle_rdata_zero", rsp_rdata, 32'd0);
                check("idle_cmd_rdy", 32'(cmd_rdy), 32'd1);
                if (mon_stall) check("stalled_rsp_dropped", 32'(rsp_vld), 32'd1);
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    check("stall_rdata_stable", rsp_rdata, mon_data);
                    check("stall_err_stable", 32'(rsp_err), 32'(mon_err));
                end else if (exp_q.size() == 0) begin
                    check("spurious_rsp_vld", 32'(rsp_vld), 32'd0);
                end else begin
                    check("rsp_latency", cyc, exp_q[0].cyc + 1);
                end
                if (!rsp_rdy) begin
                    check("stall_cmd_rdy", 32'(cmd_rdy), 32'd0);
                    check("stall_sram_cs", 32'(sram_cs), 32'd0);
                    mon_stall = 1'b1;
                    mon_data  = rsp_rdata;
                    mon_err   = rsp_err;
                end else begin
                    mon_stall = 1'b0;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int          wt;
        int          r;
        logic [31:0] a;
        logic        w;
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
            ref_mem[i]  = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
        end
        sram_mem[4] = 32'h0051_3093;
        ref_mem[4]  = 32'h0051_3093;

        // Reset with a command pending on the bus: nothing may be accepted.
        reset_n = 1'b0; rsp_rdy = 1'b1;
        cmd_vld = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010;
        cmd_wdata = 32'd0; cmd_wstrb = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        cmd_vld = 1'b0; reset_n = 1'b1;
        @(posedge clk); #1;

        // Single read of the known instruction word.
        issue(1'b0, 32'h0000_0010, 32'd0, 4'b0000, wt);

        // Back-to-back reads: each must be accepted without waiting.
        issue(1'b0, 32'h0000_0000, 32'd0, 4'b0000, wt); check("b2b_wait0", 32'(wt), 32'd0);
        issue(1'b0, 32'h0000_0004, 32'd0, 4'b0000, wt); check("b2b_wait1", 32'(wt), 32'd0);
        issue(1'b0, 32'h0000_0008, 32'd0, 4'b0000, wt); check("b2b_wait2", 32'(wt), 32'd0);
        @(posedge clk); #1;

        // Stall for three cycles while the SRAM output turns to garbage.
        rsp_rdy = 1'b0;
        issue(1'b0, 32'h0000_0008, 32'd0, 4'b0000, wt);
        repeat (3) begin @(posedge clk); #1; end
        rsp_rdy = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("stall_single_handshake", 32'(exp_q.size()), 32'd0);

        // Error reads, window edges and wrapped address.
        issue(1'b0, 32'h0000_0002, 32'd0, 4'b0000, wt);
        issue(1'b0, 32'h0001_0000, 32'd0, 4'b0000, wt);
        issue(1'b0, 32'h0000_FFFC, 32'd0, 4'b0000, wt);
        issue(1'b0, 32'hFFFF_FFFC, 32'd0, 4'b0000, wt);

        // Partial write then readback.
        issue(1'b1, 32'h0000_0020, 32'h1122_3344, 4'b0011, wt);
        issue(1'b0, 32'h0000_0020, 32'd0, 4'b0000, wt);
        @(posedge clk); #1;

        // Reset while a response is held.
        rsp_rdy = 1'b0;
        issue(1'b0, 32'h0000_0008, 32'd0, 4'b0000, wt);
        @(posedge clk); #1;
        reset_n = 1'b0; cmd_vld = 1'b1; cmd_addr = 32'h0000_0004; cmd_write = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1; cmd_vld = 1'b0; rsp_rdy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // Randomized traffic with random back-pressure and idle gaps.
        for (int n = 0; n < 400; n++) begin
            rsp_rdy = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5: a = {16'd0, 14'($urandom_range(0, WORDS - 1)), 2'b00};
                6: a = {16'd0, 14'($urandom_range(0, WORDS - 1)), 2'($urandom_range(1, 3))};
                7: a = $urandom() | 32'h0001_0000;
                8: a = ($urandom_range(0, 1) != 0) ? 32'h0000_FFFC : 32'h0001_0000;
                default: a = 32'h0000_0020 + {26'd0, 4'($urandom_range(0, 7)), 2'b00};
            endcase
            w = ($urandom_range(0, 2) == 0);
            issue(w, a, $urandom(), 4'($urandom_range(0, 15)), wt);
            if ($urandom_range(0, 3) == 0) begin
                rsp_rdy = ($urandom_range(0, 1) != 0);
                @(posedge clk); #1;
            end
        end

        // Drain.
        rsp_rdy = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
